// File: rtl/fp_align_shifter.sv
// Alignment stage of the FP adder: right-shifts the smaller operand's fraction by the
// exponent difference, up to STEP bits per cycle, folding discarded bits into a sticky bit.
module fp_align_shifter #(
  parameter int FRAC_W = 32,
  parameter int EXP_W  = 8,
  parameter int STEP   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [FRAC_W-1:0] in_frac,
  input  logic [EXP_W-1:0]  in_shamt,
  input  logic              in_sign,
  input  logic [EXP_W-1:0]  in_exp,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [FRAC_W-1:0] out_frac,
  output logic              out_sticky,
  output logic              out_sign,
  output logic [EXP_W-1:0]  out_exp,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [EXP_W:0]   SAT_LIM = (EXP_W+1)'(FRAC_W);
  localparam logic [EXP_W-1:0] STEP_K  = EXP_W'(STEP);

  state_t              state;
  logic [FRAC_W-1:0]   frac;
  logic                sticky;
  logic                sign_q;
  logic [EXP_W-1:0]    exp_q;
  logic [EXP_W-1:0]    count;
  logic                rdy_q;
  logic                vld_q;
  logic                busy_q;

  logic [EXP_W-1:0]    k;
  logic [FRAC_W-1:0]   shifted;
  logic [FRAC_W-1:0]   lost_mask;
  logic                lost;

  // k never exceeds STEP, so the shift and mask stay well inside the datapath
  always_comb begin
    k         = (count < STEP_K) ? count : STEP_K;
    shifted   = frac >> k;
    lost_mask = ~({FRAC_W{1'b1}} << k);
    lost      = |(frac & lost_mask);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      frac   <= '0;
      sticky <= 1'b0;
      sign_q <= 1'b0;
      exp_q  <= '0;
      count  <= '0;
      rdy_q  <= 1'b1;
      vld_q  <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sign_q <= in_sign;
            exp_q  <= in_exp;
            count  <= in_shamt;
            sticky <= 1'b0;
            rdy_q  <= 1'b0;
            busy_q <= 1'b1;
            if (in_frac == '0) begin
              frac  <= '0;
              state <= DONE;
              vld_q <= 1'b1;
            end else if ({1'b0, in_shamt} >= SAT_LIM) begin
              // everything falls off the end: no need to iterate
              frac   <= '0;
              sticky <= |in_frac;
              state  <= DONE;
              vld_q  <= 1'b1;
            end else if (in_shamt == '0) begin
              frac  <= in_frac;
              state <= DONE;
              vld_q <= 1'b1;
            end else begin
              frac  <= in_frac;
              state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          frac   <= shifted;
          sticky <= sticky | lost;
          count  <= count - k;
          if (count == k || shifted == '0) begin
            state <= DONE;
            vld_q <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state  <= IDLE;
            vld_q  <= 1'b0;
            busy_q <= 1'b0;
            rdy_q  <= 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          vld_q  <= 1'b0;
          busy_q <= 1'b0;
          rdy_q  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready   = rdy_q;
  assign out_valid  = vld_q;
  assign busy       = busy_q;
  assign out_frac   = frac;
  assign out_sticky = sticky;
  assign out_sign   = sign_q;
  assign out_exp    = exp_q;

endmodule

// File: tb/tb_fp_align_shifter.sv
// Scoreboard bench for fp_align_shifter: one STEP=1 and one STEP=4 instance, exercised in turn.
module tb_fp_align_shifter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_frac = '0;
  logic [7:0]  in_shamt = '0;
  logic        in_sign = 1'b0;
  logic [7:0]  in_exp = '0;
  logic        ordy_force = 1'b1;
  logic        rnd = 1'b0;
  logic        rnd_bit = 1'b1;
  logic        out_ready;

  logic        ir1, ov1, os1, sg1, bz1, ir4, ov4, os4, sg4, bz4;
  logic [31:0] of1, of4;
  logic [7:0]  ex1, ex4;

  logic        in_ready, out_valid, out_sticky, out_sign, busy;
  logic [31:0] out_frac;
  logic [7:0]  out_exp;

  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;
  int cur_step = 1;

  typedef struct {
    logic [31:0] frac;
    logic        sticky;
    logic        sign;
    logic [7:0]  exp;
    int          lat;
    int          acc;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rnd_bit <= ($urandom_range(0, 3) != 0);

  assign out_ready = rnd ? rnd_bit : ordy_force;

  fp_align_shifter #(.FRAC_W(32), .EXP_W(8), .STEP(1)) u_s1 (
    .clk(clk), .rst(rst), .in_valid(in_valid & ~sel), .in_ready(ir1),
    .in_frac(in_frac), .in_shamt(in_shamt), .in_sign(in_sign), .in_exp(in_exp),
    .out_valid(ov1), .out_ready(out_ready & ~sel), .out_frac(of1), .out_sticky(os1),
    .out_sign(sg1), .out_exp(ex1), .busy(bz1));

  fp_align_shifter #(.FRAC_W(32), .EXP_W(8), .STEP(4)) u_s4 (
    .clk(clk), .rst(rst), .in_valid(in_valid & sel), .in_ready(ir4),
    .in_frac(in_frac), .in_shamt(in_shamt), .in_sign(in_sign), .in_exp(in_exp),
    .out_valid(ov4), .out_ready(out_ready & sel), .out_frac(of4), .out_sticky(os4),
    .out_sign(sg4), .out_exp(ex4), .busy(bz4));

  assign in_ready   = sel ? ir4 : ir1;
  assign out_valid  = sel ? ov4 : ov1;
  assign out_frac   = sel ? of4 : of1;
  assign out_sticky = sel ? os4 : os1;
  assign out_sign   = sel ? sg4 : sg1;
  assign out_exp    = sel ? ex4 : ex1;
  assign busy       = sel ? bz4 : bz1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s (step %0d, cycle %0d): got 0x%0h, expected 0x%0h", tag, cur_step, cyc, obs, expv);
    end
  endtask

  function automatic int lat_of(input logic [31:0] f, input logic [7:0] sh, input int st);
    int p, ns, nz;
    if (sh == 0 || sh >= 32 || f == 0) return 1;
    p = 0;
    for (int i = 0; i < 32; i++) if (f[i]) p = i;
    ns = (int'(sh) + st - 1) / st;
    nz = p / st + 1;
    return 1 + ((ns < nz) ? ns : nz);
  endfunction

  function automatic exp_t model(input logic [31:0] f, input logic [7:0] sh, input logic s,
                                 input logic [7:0] e, input int st);
    exp_t r;
    logic [63:0] m;
    r.sign = s;
    r.exp  = e;
    if (sh >= 32) begin
      r.frac   = '0;
      r.sticky = |f;
    end else begin
      m        = (64'd1 << sh) - 64'd1;
      r.frac   = f >> sh;
      r.sticky = |({32'd0, f} & m);
    end
    r.lat = lat_of(f, sh, st);
    r.acc = 0;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_op(input logic [31:0] f, input logic [7:0] sh, input logic s,
                         input logic [7:0] e, input bit push);
    int n = 0;
    exp_t r;
    in_valid = 1'b1;
    in_frac  = f;
    in_shamt = sh;
    in_sign  = s;
    in_exp   = e;
    while (!in_ready && n < 300) begin
      tick();
      n++;
    end
    if (!in_ready) chk("accept_timeout", 0, 1);
    tick();
    if (push) begin
      r = model(f, sh, s, e, cur_step);
      r.acc = cyc;
      sb.push_back(r);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 5000) begin
      tick();
      n++;
    end
    chk("drain", sb.size(), 0);
  endtask

  // scoreboard side: compare on each output handshake
  bit vseen = 0;
  int vcyc = 0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      vseen = 0;
    end else begin
      if (out_valid && !vseen) begin
        vseen = 1;
        vcyc  = cyc;
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("stray_handshake", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("frac", out_frac, e.frac);
          chk("sticky", out_sticky, e.sticky);
          chk("sign", out_sign, e.sign);
          chk("exp", out_exp, e.exp);
          chk("latency", vcyc - e.acc + 1, e.lat);
        end
        vseen = 0;
      end
    end
  end

  task automatic run_suite();
    logic [31:0] snap_f;
    logic        snap_s;
    int          n;
    // reset while shifting
    ordy_force = 1'b1;
    send_op(32'hFFFF_FFFF, 8'd20, 1'b1, 8'h7F, 1'b0);
    tick();
    tick();
    chk("mid_busy", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frac", out_frac, 0);
    chk("rst_sticky", out_sticky, 0);
    chk("rst_sign", out_sign, 0);
    chk("rst_exp", out_exp, 0);
    repeat (25) tick();
    chk("rst_no_valid", out_valid, 0);

    // directed operands
    send_op(32'h00C0_0000, 8'd0,   1'b1, 8'h85, 1'b1);
    send_op(32'h0080_0001, 8'd3,   1'b0, 8'h10, 1'b1);
    send_op(32'h0080_0000, 8'd40,  1'b0, 8'h20, 1'b1);
    send_op(32'h0000_0000, 8'd40,  1'b1, 8'h21, 1'b1);
    send_op(32'h00FF_FFF0, 8'd10,  1'b0, 8'h30, 1'b1);
    send_op(32'hFFFF_FFFF, 8'd255, 1'b1, 8'hFF, 1'b1);
    send_op(32'h1234_5678, 8'd32,  1'b0, 8'h40, 1'b1);
    send_op(32'h8000_0000, 8'd31,  1'b0, 8'h41, 1'b1);
    send_op(32'h7FFF_FFFF, 8'd31,  1'b1, 8'h42, 1'b1);
    send_op(32'h0000_000F, 8'd20,  1'b0, 8'h43, 1'b1);
    send_op(32'h0000_0000, 8'd5,   1'b0, 8'h44, 1'b1);
    drain();

    // hold in DONE with backpressure while a second operand waits
    ordy_force = 1'b0;
    send_op(32'hA5A5_A5A5, 8'd6, 1'b1, 8'h55, 1'b1);
    n = 0;
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
    chk("hold_valid", out_valid, 1);
    snap_f = out_frac;
    snap_s = out_sticky;
    in_valid = 1'b1;
    in_frac  = 32'h0F0F_0F0F;
    in_shamt = 8'd4;
    in_sign  = 1'b0;
    in_exp   = 8'h66;
    repeat (5) begin
      tick();
      chk("hold_frac", out_frac, snap_f);
      chk("hold_sticky", out_sticky, snap_s);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_out_valid", out_valid, 1);
    end
    ordy_force = 1'b1;
    tick();
    chk("release_out_valid", out_valid, 0);
    chk("release_in_ready", in_ready, 1);
    send_op(32'h0F0F_0F0F, 8'd4, 1'b0, 8'h66, 1'b1);
    drain();

    // random operands with random backpressure
    rnd = 1'b1;
    for (int i = 0; i < 200; i++) begin
      logic [31:0] f;
      logic [7:0]  sh;
      f  = ($urandom_range(0, 9) == 0) ? 32'd0 : 32'($urandom);
      sh = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 35));
      send_op(f, sh, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'b1);
      if ($urandom_range(0, 3) == 0) tick();
    end
    rnd = 1'b0;
    drain();
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) tick();
    chk("init_in_ready", in_ready, 1);
    chk("init_out_valid", out_valid, 0);
    chk("init_busy", busy, 0);
    chk("init_frac", out_frac, 0);
    rst = 1'b0;
    tick();

    sel = 1'b0;
    cur_step = 1;
    run_suite();

    sel = 1'b1;
    cur_step = 4;
    tick();
    run_suite();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fp_align_shifter.md
Name: fp_align_shifter

Overview:
Sequential alignment stage of the floating-point adder. It sits directly downstream of the operand-select multiplexers. It takes the fraction of the smaller-exponent operand, with the hidden bit included, and right-shifts it by the exponent difference so it lines up with the larger operand's fraction. Shifted-out bits are collapsed into a sticky bit for later rounding. Sign and exponent pass through as sideband, and a valid/ready handshake sits on both sides.

Parameters:
FRAC_W, 32, fraction datapath width in bits (hidden bit included).
EXP_W, 8, exponent and shift-amount width in bits.
STEP, 1, maximum right-shift per cycle; legal values 1, 2, 4, 8.

Ports:
clk  input  1  single clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  upstream presents an operand.
in_ready  output  1  block can accept an operand.
in_frac  input  FRAC_W  fraction to align (smaller operand, from the fraction mux).
in_shamt  input  EXP_W  exponent difference (unsigned right-shift amount).
in_sign  input  1  sign sideband (from the sign mux).
in_exp  input  EXP_W  larger exponent sideband (from the exponent mux).
out_valid  output  1  aligned result available.
out_ready  input  1  downstream accepts the result.
out_frac  output  FRAC_W  aligned fraction.
out_sticky  output  1  OR of every bit shifted out.
out_sign  output  1  registered in_sign.
out_exp  output  EXP_W  registered in_exp.
busy  output  1  high in SHIFT or DONE.

Behaviour:
- States are IDLE, SHIFT and DONE.
- On rst (synchronous): state=IDLE; in_ready=1; out_valid=0; busy=0; out_frac=0; out_sticky=0; out_sign=0; out_exp=0; internal count=0.
- Reset mid-operation discards the operand in flight; no output handshake occurs for it.
- IDLE:
  - in_ready=1.
  - Accept when in_valid=1: latch frac, sign and exp; set sticky=0; set count=in_shamt.
  - in_shamt==0 -> DONE, frac unchanged.
  - in_shamt>=FRAC_W -> DONE with frac=0 and sticky=|in_frac (saturating case, no iteration).
  - in_frac==0 -> DONE with frac=0 and sticky=0, regardless of shift amount.
  - Otherwise -> SHIFT.
- SHIFT:
  - Each cycle, k=min(STEP,count); frac>>=k (zero fill); sticky|=OR of the k bits shifted out; count-=k.
  - When count reaches 0, or the post-shift frac is 0, -> DONE in the same update.
  - in_ready=0; in_valid is ignored.
- DONE:
  - out_valid=1; outputs are stable and must not change while out_valid=1 and out_ready=0.
  - When out_ready=1 -> IDLE; out_valid drops the next cycle.
  - No accept occurs in the same cycle as the output handshake. in_ready goes high the cycle after leaving DONE.
- Latency from the accept edge to out_valid high:
  - 1 cycle for shamt==0, shamt>=FRAC_W, or in_frac==0.
  - Otherwise 1+ceil(shamt/STEP) cycles, or fewer if frac reaches zero early.
- Shift amounts are treated as unsigned, with no wrap. Values in FRAC_W..2^EXP_W-1 all take the saturating path.
- Sideband (out_sign, out_exp) equals the values latched at accept, unmodified.
- out_frac is identical to a combinational frac>>shamt (0 for shamt>=FRAC_W). out_sticky is identical to the OR of the discarded low bits. Both hold for every STEP value.
- busy = (state != IDLE).

Test Plan:
- Reset while in SHIFT with in_frac=0xFFFFFFFF, in_shamt=20 -> next cycle IDLE, in_ready=1, out_valid=0, all outputs 0, no stray handshake.
- in_frac=0x00C00000, in_shamt=0, sign=1, exp=0x85 -> out_valid 1 cycle after accept; out_frac=0x00C00000, sticky=0, sign=1, exp=0x85.
- in_frac=0x00800001, in_shamt=3, STEP=1 -> out_valid 4 cycles after accept; out_frac=0x00100000, sticky=1.
- in_frac=0x00800000, in_shamt=40 -> 1-cycle latency, out_frac=0, sticky=1. Same with in_frac=0 -> out_frac=0, sticky=0.
- STEP=4, in_frac=0x00FFFFF0, in_shamt=10 -> out_valid after 1+3 cycles; out_frac=0x00003FFF, sticky=1 (discarded bits 0x3F0 nonzero).
- Hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 with new data -> outputs frozen, in_ready=0, second operand not accepted. Raise out_ready -> IDLE next cycle, then second operand accepted; 200 random operands match the reference shift/sticky model.
